// File: rtl/mmio_resp_pkg.sv
// mmio_resp_pkg
// Shared constants for the MMIO responder: register offsets within the
// 32-byte window and the bit positions used in the status registers.
package mmio_resp_pkg;

  // Register offsets relative to the window base (window spans 0x00..0x1F)
  localparam logic [4:0] OFF_OUT_DATA = 5'h00;
  localparam logic [4:0] OFF_OUT_STAT = 5'h04;
  localparam logic [4:0] OFF_IN_DATA  = 5'h08;
  localparam logic [4:0] OFF_IN_STAT  = 5'h0C;
  localparam logic [4:0] OFF_CYCLE    = 5'h10;
  localparam logic [4:0] OFF_LED      = 5'h14;

  // Size of the decoded window in bytes
  localparam logic [31:0] WINDOW_BYTES = 32'd32;

  // Status register bit indices
  localparam int STAT_NOT_FULL_BIT = 0;
  localparam int STAT_OVERFLOW_BIT = 1;
  localparam int STAT_IN_FULL_BIT  = 0;

endpackage

// File: rtl/mmio_resp_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with registered storage. A push while full is accepted
// only when a pop happens in the same cycle, so a full FIFO can stream.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, din_i      write request and data
//   pop_i              read request (ignored while empty)
//   head_o             word at the read pointer
//   full_o, empty_o    occupancy flags
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [PW:0]      count_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];

  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  // Storage is never reset; only the pointers and count define validity
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= din_i;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= (wrPtr_q == LAST_IDX) ? '0 : wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= (rdPtr_q == LAST_IDX) ? '0 : rdPtr_q + 1'b1;
      end
      if (doPush && !doPop) begin
        count_q <= count_q + 1'b1;
      end else if (doPop && !doPush) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_resp.sv
// mmio_resp
// Memory-mapped responder sitting in a 32-byte window of the CPU address
// space: an output FIFO toward the PDU, a one-word input holding register,
// a free-running cycle counter and a 16-bit LED register.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   mem_addr/mem_we/mem_din      CPU access
//   mem_dout, mmio_hit           combinational read data and window decode
//   out_valid/out_data/out_ready output stream toward the PDU
//   in_valid/in_data/in_ready    input stream from the PDU
//   led                          LED register
module mmio_resp
  import mmio_resp_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0000_7F00,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mmio_hit,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [15:0] led
);

  logic [31:0] offset;
  logic [4:0]  regOff;
  logic        wrEn;
  logic        wrOutData, wrOutStat, wrInStat, wrCycle, wrLed;
  logic        fifoFull, fifoEmpty, fifoPop;
  logic        overflow_q, overflow_d;
  logic        inFull_q, inFull_d;
  logic [31:0] inData_q;
  logic [31:0] cycle_q, cycle_d;
  logic [15:0] led_q;
  logic        inCapture;
  logic [31:0] rdData;

  // Subtracting the base first makes addresses below BASE wrap to large
  // values, so a single unsigned compare covers both window bounds.
  assign offset   = mem_addr - BASE;
  assign mmio_hit = (offset < WINDOW_BYTES);
  assign regOff   = offset[4:0];
  assign wrEn     = mem_we && mmio_hit;

  assign wrOutData = wrEn && (regOff == OFF_OUT_DATA);
  assign wrOutStat = wrEn && (regOff == OFF_OUT_STAT);
  assign wrInStat  = wrEn && (regOff == OFF_IN_STAT);
  assign wrCycle   = wrEn && (regOff == OFF_CYCLE);
  assign wrLed     = wrEn && (regOff == OFF_LED);

  assign out_valid = !fifoEmpty;
  assign fifoPop   = out_valid && out_ready;
  assign in_ready  = !inFull_q;
  assign inCapture = in_valid && in_ready;
  assign led       = led_q;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_outFifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (wrOutData),
    .din_i   (mem_din),
    .pop_i   (fifoPop),
    .head_o  (out_data),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Next-state logic; overflow set is applied after the clear so it wins
  always_comb begin
    overflow_d = overflow_q;
    if (wrOutStat && mem_din[STAT_OVERFLOW_BIT]) begin
      overflow_d = 1'b0;
    end
    if (wrOutData && fifoFull && !fifoPop) begin
      overflow_d = 1'b1;
    end

    inFull_d = inFull_q;
    if (inCapture) begin
      inFull_d = 1'b1;
    end else if (wrInStat) begin
      inFull_d = 1'b0;
    end

    cycle_d = wrCycle ? mem_din : cycle_q + 32'd1;
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      inFull_q   <= 1'b0;
      inData_q   <= '0;
      cycle_q    <= '0;
      led_q      <= '0;
    end else begin
      overflow_q <= overflow_d;
      inFull_q   <= inFull_d;
      cycle_q    <= cycle_d;
      if (inCapture) begin
        inData_q <= in_data;
      end
      if (wrLed) begin
        led_q <= mem_din[15:0];
      end
    end
  end

  // Read mux; anything outside the window or unmapped reads as zero
  always_comb begin
    rdData = '0;
    if (mmio_hit) begin
      case (regOff)
        OFF_OUT_STAT: begin
          rdData[STAT_NOT_FULL_BIT] = !fifoFull;
          rdData[STAT_OVERFLOW_BIT] = overflow_q;
        end
        OFF_IN_DATA:  rdData = inData_q;
        OFF_IN_STAT:  rdData[STAT_IN_FULL_BIT] = inFull_q;
        OFF_CYCLE:    rdData = cycle_q;
        OFF_LED:      rdData = {16'h0000, led_q};
        default:      rdData = '0;
      endcase
    end
  end

  assign mem_dout = rdData;

endmodule

// File: tb/tb_mmio_resp.sv
`timescale 1ns/1ps
// tb_mmio_resp
// Directed vector table for the register map, FIFO and input channel,
// followed by a hand-written asynchronous reset sequence.
module tb_mmio_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_din = '0;
  logic [31:0] mem_dout;
  logic        mmio_hit;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [15:0] led;

  int checksTotal  = 0;
  int checksPassed = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic        ordy;
    logic        ival;
    logic [31:0] idata;
    logic        chkDout;
    logic [31:0] expDout;
    logic        expOv;
    logic [31:0] expOd;
    logic        expHit;
    logic        expInRdy;
  } vec_t;

  vec_t vecs[$];

  mmio_resp #(
    .BASE       (32'h0000_7F00),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mmio_hit  (mmio_hit),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .led       (led)
  );

  always #10 clk = ~clk;

  function automatic vec_t mk(string n, logic [31:0] a, logic w, logic [31:0] d,
                              logic ordy, logic iv, logic [31:0] id,
                              logic cd, logic [31:0] ed, logic eov,
                              logic [31:0] eod, logic eh, logic eir);
    vec_t v;
    v.name = n; v.addr = a; v.we = w; v.din = d; v.ordy = ordy;
    v.ival = iv; v.idata = id; v.chkDout = cd; v.expDout = ed;
    v.expOv = eov; v.expOd = eod; v.expHit = eh; v.expInRdy = eir;
    return v;
  endfunction

  task automatic applyStimulus(logic [31:0] a, logic w, logic [31:0] d,
                               logic ordy, logic iv, logic [31:0] id);
    mem_addr  = a;
    mem_we    = w;
    mem_din   = d;
    out_ready = ordy;
    in_valid  = iv;
    in_data   = id;
  endtask

  task automatic checkOutput(string n, logic [31:0] act, logic [31:0] exp);
    checksTotal++;
    if (act === exp) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Read-only helper: address, check read data, wait the next edge
  function automatic vec_t rd(string n, logic [31:0] a, logic ordy,
                              logic [31:0] ed, logic eov, logic [31:0] eod,
                              logic eir);
    return mk(n, a, 1'b0, 32'h0, ordy, 1'b0, 32'h0, 1'b1, ed, eov, eod, 1'b1, eir);
  endfunction

  function automatic vec_t wr(string n, logic [31:0] a, logic [31:0] d,
                              logic ordy, logic [31:0] ed, logic eov,
                              logic [31:0] eod);
    return mk(n, a, 1'b1, d, ordy, 1'b0, 32'h0, 1'b1, ed, eov, eod, 1'b1, 1'b1);
  endfunction

  initial begin
    // Output FIFO fill, overflow, sticky clear and drain
    vecs.push_back(rd("stat_reset", 32'h7F04, 0, 32'h1, 0, 0, 1));
    vecs.push_back(wr("push11", 32'h7F00, 32'h11, 0, 32'h0, 0, 0));
    vecs.push_back(wr("push22", 32'h7F00, 32'h22, 0, 32'h0, 1, 32'h11));
    vecs.push_back(wr("push33", 32'h7F00, 32'h33, 0, 32'h0, 1, 32'h11));
    vecs.push_back(wr("push44", 32'h7F00, 32'h44, 0, 32'h0, 1, 32'h11));
    vecs.push_back(rd("stat_full", 32'h7F04, 0, 32'h0, 1, 32'h11, 1));
    vecs.push_back(wr("push55_ovf", 32'h7F00, 32'h55, 0, 32'h0, 1, 32'h11));
    vecs.push_back(rd("stat_ovf", 32'h7F04, 0, 32'h2, 1, 32'h11, 1));
    vecs.push_back(wr("clr_bit0_only", 32'h7F04, 32'h1, 0, 32'h2, 1, 32'h11));
    vecs.push_back(rd("stat_ovf_kept", 32'h7F04, 0, 32'h2, 1, 32'h11, 1));
    vecs.push_back(rd("pop11", 32'h7F04, 1, 32'h2, 1, 32'h11, 1));
    vecs.push_back(rd("pop22", 32'h7F04, 1, 32'h3, 1, 32'h22, 1));
    vecs.push_back(rd("pop33", 32'h7F04, 1, 32'h3, 1, 32'h33, 1));
    vecs.push_back(rd("pop44", 32'h7F04, 1, 32'h3, 1, 32'h44, 1));
    vecs.push_back(rd("drained", 32'h7F04, 0, 32'h3, 0, 0, 1));
    vecs.push_back(wr("clr_ovf", 32'h7F04, 32'h2, 0, 32'h3, 0, 0));
    vecs.push_back(rd("stat_cleared", 32'h7F04, 0, 32'h1, 0, 0, 1));
    // Push into a full FIFO in the same cycle as a pop
    vecs.push_back(wr("push61", 32'h7F00, 32'h61, 0, 32'h0, 0, 0));
    vecs.push_back(wr("push62", 32'h7F00, 32'h62, 0, 32'h0, 1, 32'h61));
    vecs.push_back(wr("push63", 32'h7F00, 32'h63, 0, 32'h0, 1, 32'h61));
    vecs.push_back(wr("push64", 32'h7F00, 32'h64, 0, 32'h0, 1, 32'h61));
    vecs.push_back(wr("push66_pop", 32'h7F00, 32'h66, 1, 32'h0, 1, 32'h61));
    vecs.push_back(rd("stat_no_ovf", 32'h7F04, 0, 32'h0, 1, 32'h62, 1));
    vecs.push_back(rd("pop62", 32'h7F04, 1, 32'h0, 1, 32'h62, 1));
    vecs.push_back(rd("pop63", 32'h7F04, 1, 32'h1, 1, 32'h63, 1));
    vecs.push_back(rd("pop64", 32'h7F04, 1, 32'h1, 1, 32'h64, 1));
    vecs.push_back(rd("pop66", 32'h7F04, 1, 32'h1, 1, 32'h66, 1));
    vecs.push_back(rd("drained2", 32'h7F04, 0, 32'h1, 0, 0, 1));
    // Window decode and unmapped offsets
    vecs.push_back(rd("unmapped18", 32'h7F18, 0, 32'h0, 0, 0, 1));
    vecs.push_back(rd("unmapped1F", 32'h7F1F, 0, 32'h0, 0, 0, 1));
    vecs.push_back(mk("miss7F20", 32'h7F20, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 1));
    vecs.push_back(mk("miss7EFF", 32'h7EFF, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 1));
    vecs.push_back(mk("miss_wr_led", 32'h7F34, 1, 32'hBEEF, 0, 0, 0, 1, 32'h0, 0, 0, 0, 1));
    vecs.push_back(rd("led_untouched", 32'h7F14, 0, 32'h0, 0, 0, 1));
    vecs.push_back(wr("wr_led", 32'h7F14, 32'hFFFF_A5A5, 0, 32'h0, 0, 0));
    vecs.push_back(rd("rd_led", 32'h7F14, 0, 32'h0000_A5A5, 0, 0, 1));
    vecs.push_back(mk("miss_wr_led0", 32'h7F34, 1, 32'h0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 1));
    vecs.push_back(rd("rd_led_kept", 32'h7F14, 0, 32'h0000_A5A5, 0, 0, 1));
    vecs.push_back(mk("miss_wr_fifo", 32'h7F20, 1, 32'h99, 0, 0, 0, 1, 32'h0, 0, 0, 0, 1));
    vecs.push_back(rd("no_push_on_miss", 32'h7F04, 0, 32'h1, 0, 0, 1));
    // Input channel capture, hold and release
    vecs.push_back(mk("in_offer", 32'h7F0C, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'h0, 0, 0, 1, 1));
    vecs.push_back(mk("in_held", 32'h7F0C, 0, 0, 0, 1, 32'h1234_5678, 1, 32'h1, 0, 0, 1, 0));
    vecs.push_back(mk("in_data", 32'h7F08, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 1, 0));
    vecs.push_back(mk("in_clr_wr", 32'h7F0C, 1, 0, 0, 0, 0, 1, 32'h1, 0, 0, 1, 0));
    vecs.push_back(rd("in_released", 32'h7F0C, 0, 32'h0, 0, 0, 1));
    vecs.push_back(rd("in_data_kept", 32'h7F08, 0, 32'hDEAD_BEEF, 0, 0, 1));
    // CYCLE load and wrap
    vecs.push_back(mk("cyc_load", 32'h7F10, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1));
    vecs.push_back(rd("cyc_fffe", 32'h7F10, 0, 32'hFFFF_FFFE, 0, 0, 1));
    vecs.push_back(rd("cyc_ffff", 32'h7F10, 0, 32'hFFFF_FFFF, 0, 0, 1));
    vecs.push_back(rd("cyc_wrap", 32'h7F10, 0, 32'h0000_0000, 0, 0, 1));
    vecs.push_back(rd("cyc_one", 32'h7F10, 0, 32'h0000_0001, 0, 0, 1));

    // Reset release happens on a falling edge so the next rising edge is the first count
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].din, vecs[i].ordy,
                    vecs[i].ival, vecs[i].idata);
      #1;
      checkOutput({vecs[i].name, ".hit"}, {31'h0, mmio_hit}, {31'h0, vecs[i].expHit});
      checkOutput({vecs[i].name, ".in_ready"}, {31'h0, in_ready}, {31'h0, vecs[i].expInRdy});
      checkOutput({vecs[i].name, ".out_valid"}, {31'h0, out_valid}, {31'h0, vecs[i].expOv});
      if (vecs[i].expOv) begin
        checkOutput({vecs[i].name, ".out_data"}, out_data, vecs[i].expOd);
      end
      if (vecs[i].chkDout) begin
        checkOutput({vecs[i].name, ".dout"}, mem_dout, vecs[i].expDout);
      end
    end

    // Reset mid-stream: two words queued, an input word held, LEDs lit
    @(negedge clk);
    applyStimulus(32'h7F00, 1'b1, 32'hAA, 1'b0, 1'b1, 32'hCAFE_F00D);
    @(negedge clk);
    applyStimulus(32'h7F00, 1'b1, 32'hBB, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(32'h7F10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("pre_rst.out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("pre_rst.out_data", out_data, 32'hAA);
    checkOutput("pre_rst.led", {16'h0, led}, 32'h0000_A5A5);
    checkOutput("pre_rst.in_ready", {31'h0, in_ready}, 32'h0);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst.out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst.led", {16'h0, led}, 32'h0);
    checkOutput("rst.in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("rst.cycle", mem_dout, 32'h0);
    mem_addr = 32'h7F08;
    #1;
    checkOutput("rst.in_data", mem_dout, 32'h0);
    mem_addr = 32'h7F04;
    #1;
    checkOutput("rst.out_stat", mem_dout, 32'h1);
    mem_addr = 32'h0000_1000;
    #1;
    checkOutput("rst.miss_hit", {31'h0, mmio_hit}, 32'h0);
    checkOutput("rst.miss_dout", mem_dout, 32'h0);

    // First CYCLE increment lands on the first edge after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_addr = 32'h7F10;
    #1;
    checkOutput("rel.cycle0", mem_dout, 32'h0);
    checkOutput("rel.out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rel.cycle1", mem_dout, 32'h1);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
